lsu_mem_arbiter: RTL and testbench

Shares the single data-memory port between two requesters: the core LSU and a debug/DMA loader port. Arbitration is round-robin, with a valid/grant handshake and a fixed read latency. Sits between lsu and the synchronous data SRAM. Raises a stall to the core so the PC register holds while the core's access is pending.

---
 rtl/lsu_mem_arbiter_pkg.sv | 21 ++
 rtl/lsu_mem_arbiter_arb_rr2.sv | 22 ++
 rtl/lsu_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types and constants for the LSU / debug-port data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_req_e   : requester identity, also the bit index in request/grant vectors
//   ARB_MAX_LAT : largest supported SRAM read latency
//   ARB_CNT_W   : width of the read-latency down-counter
package lsu_mem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_e;

    typedef enum logic [0:0] {
        REQ_CORE,
        REQ_DBG
    } arb_req_e;

    localparam int ARB_MAX_LAT = 4;
    localparam int ARB_CNT_W   = $clog2(ARB_MAX_LAT);

endpackage

// File: rtl/lsu_mem_arbiter_arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker.
// Ports:
//   req         in  [1:0]  request vector, bit REQ_CORE = core, bit REQ_DBG = debug
//   last_served in         requester that won the previous grant
//   gnt         out [1:0]  one-hot grant (all zero when nobody requests)
module arb_rr2
    import lsu_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  arb_req_e   last_served,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the requester that was not served last time wins.
        if (req == 2'b11) begin
            gnt = (last_served == REQ_CORE) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: shares the single synchronous data-SRAM port between the
// core LSU and the debug/DMA loader port with round-robin arbitration.
// Writes complete in the grant cycle; reads block the port for MEM_LAT cycles
// after the grant and return data with a one-cycle rvalid pulse.
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-low reset
//   i_c_* / o_c_*                  core request, grant, read return, stall
//   i_d_* / o_d_*                  debug-port request, grant, read return
//   o_m_*                          memory strobe and payload (zero when idle)
//   i_m_rdata                      memory read data, MEM_LAT cycles after a read
// MEM_LAT legal range is 1..ARB_MAX_LAT.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_c_req,
    input  logic              i_c_wren,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_wdata,
    input  logic [3:0]        i_c_bmask,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    output logic              o_c_stall,
    input  logic              i_d_req,
    input  logic              i_d_wren,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic [3:0]        i_d_bmask,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_m_req,
    output logic              o_m_wren,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    output logic [3:0]        o_m_bmask,
    input  logic [DATA_W-1:0] i_m_rdata
);

    localparam logic [ARB_CNT_W-1:0] CNT_INIT = ARB_CNT_W'(MEM_LAT - 1);

    arb_state_e            state_reg, state_next;
    logic [ARB_CNT_W-1:0]  cnt_reg, cnt_next;
    arb_req_e              owner_reg, owner_next;
    arb_req_e              last_reg, last_next;
    logic [DATA_W-1:0]     c_rdata_reg, d_rdata_reg;
    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    logic                  rd_done;

    // Requests are only considered while idle and out of reset, so grants and
    // the memory strobe are forced low as soon as reset asserts.
    assign arb_req = (state_reg == ARB_IDLE && i_reset) ? {i_d_req, i_c_req} : 2'b00;

    arb_rr2 u_rr (
        .req         (arb_req),
        .last_served (last_reg),
        .gnt         (arb_gnt)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        o_c_gnt    = arb_gnt[REQ_CORE];
        o_d_gnt    = arb_gnt[REQ_DBG];
        o_m_req    = |arb_gnt;
        o_m_wren   = 1'b0;
        o_m_addr   = '0;
        o_m_wdata  = '0;
        o_m_bmask  = 4'h0;
        rd_done    = (state_reg == ARB_RD_WAIT) && (cnt_reg == '0);
        o_c_rvalid = rd_done && (owner_reg == REQ_CORE);
        o_d_rvalid = rd_done && (owner_reg == REQ_DBG);

        case (state_reg)
            ARB_IDLE: begin
                if (arb_gnt[REQ_CORE]) begin
                    o_m_wren  = i_c_wren;
                    o_m_addr  = i_c_addr;
                    o_m_wdata = i_c_wdata;
                    o_m_bmask = i_c_bmask;
                    last_next = REQ_CORE;
                    if (!i_c_wren) begin
                        owner_next = REQ_CORE;
                        cnt_next   = CNT_INIT;
                        state_next = ARB_RD_WAIT;
                    end
                end else if (arb_gnt[REQ_DBG]) begin
                    o_m_wren  = i_d_wren;
                    o_m_addr  = i_d_addr;
                    o_m_wdata = i_d_wdata;
                    o_m_bmask = i_d_bmask;
                    last_next = REQ_DBG;
                    if (!i_d_wren) begin
                        owner_next = REQ_DBG;
                        cnt_next   = CNT_INIT;
                        state_next = ARB_RD_WAIT;
                    end
                end
            end
            ARB_RD_WAIT: begin
                // The return cycle itself grants nothing; the port reopens next cycle.
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - ARB_CNT_W'(1);
                end else begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        // Read data passes straight through on the return cycle, otherwise the
        // last value returned to that requester is held.
        o_c_rdata = o_c_rvalid ? i_m_rdata : c_rdata_reg;
        o_d_rdata = o_d_rvalid ? i_m_rdata : d_rdata_reg;

        o_c_stall = (i_reset && i_c_req && !o_c_gnt) ||
                    (state_reg == ARB_RD_WAIT && owner_reg == REQ_CORE && !o_c_rvalid);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg   <= ARB_IDLE;
            cnt_reg     <= '0;
            owner_reg   <= REQ_CORE;
            last_reg    <= REQ_DBG;
            c_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            if (o_c_rvalid) c_rdata_reg <= i_m_rdata;
            if (o_d_rvalid) d_rdata_reg <= i_m_rdata;
        end
    end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter (MEM_LAT=3): directed scenarios
// followed by random traffic, all checked every cycle against a reference
// model that tracks the port as "free" or "busy until a response cycle".
module tb_lsu_mem_arbiter;

    localparam int LAT = 3;

    logic        i_clk, i_reset;
    logic        i_c_req, i_c_wren, i_d_req, i_d_wren;
    logic [31:0] i_c_addr, i_c_wdata, i_d_addr, i_d_wdata, i_m_rdata;
    logic [3:0]  i_c_bmask, i_d_bmask;
    logic        o_c_gnt, o_c_rvalid, o_c_stall, o_d_gnt, o_d_rvalid;
    logic [31:0] o_c_rdata, o_d_rdata;
    logic        o_m_req, o_m_wren;
    logic [31:0] o_m_addr, o_m_wdata;
    logic [3:0]  o_m_bmask;

    lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_c_req(i_c_req), .i_c_wren(i_c_wren), .i_c_addr(i_c_addr),
        .i_c_wdata(i_c_wdata), .i_c_bmask(i_c_bmask),
        .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata),
        .o_c_stall(o_c_stall),
        .i_d_req(i_d_req), .i_d_wren(i_d_wren), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_bmask(i_d_bmask),
        .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_m_req(o_m_req), .o_m_wren(o_m_wren), .o_m_addr(o_m_addr),
        .o_m_wdata(o_m_wdata), .o_m_bmask(o_m_bmask), .i_m_rdata(i_m_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Bench SRAM: 16 words, indexed by address bits [5:2], read pipeline of LAT.
    logic [31:0] mem [16];
    logic [31:0] pipe [LAT];
    logic        s_req, s_wren;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_bmask;

    // Reference model state.
    int          cyc, resp_cyc;
    bit          last_was_dbg, rd_for_dbg, e_gc, e_gd;
    logic [31:0] rd_data, held_c, held_d;
    int          n_checks, n_pass, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        resp_cyc     = -1;
        last_was_dbg = 1'b1;
        rd_for_dbg   = 1'b0;
        rd_data      = '0;
        held_c       = '0;
        held_d       = '0;
    endtask

    // Mid-cycle: predict every output from the current inputs and model state,
    // compare, then advance the model by this cycle's decisions.
    task automatic check_cycle();
        bit          busy, rvc, rvd, mreq, mwren, stall;
        logic [31:0] maddr, mwdata, rdc, rdd;
        logic [3:0]  mbm;
        #1;
        if (!i_reset) model_reset();
        busy = i_reset && (cyc <= resp_cyc);
        rvc  = busy && (cyc == resp_cyc) && !rd_for_dbg;
        rvd  = busy && (cyc == resp_cyc) && rd_for_dbg;
        e_gc = 1'b0;
        e_gd = 1'b0;
        if (i_reset && !busy) begin
            if (i_c_req && i_d_req) begin
                e_gc = last_was_dbg;
                e_gd = !last_was_dbg;
            end else begin
                e_gc = i_c_req;
                e_gd = i_d_req;
            end
        end
        mreq = e_gc || e_gd;
        mwren = 1'b0; maddr = '0; mwdata = '0; mbm = '0;
        if (e_gc) begin
            mwren = i_c_wren; maddr = i_c_addr; mwdata = i_c_wdata; mbm = i_c_bmask;
        end else if (e_gd) begin
            mwren = i_d_wren; maddr = i_d_addr; mwdata = i_d_wdata; mbm = i_d_bmask;
        end
        rdc   = rvc ? rd_data : held_c;
        rdd   = rvd ? rd_data : held_d;
        stall = (i_reset && i_c_req && !e_gc) || (busy && !rd_for_dbg && !rvc);

        chk("c_gnt", o_c_gnt, e_gc);
        chk("d_gnt", o_d_gnt, e_gd);
        chk("c_rvalid", o_c_rvalid, rvc);
        chk("d_rvalid", o_d_rvalid, rvd);
        chk("c_rdata", o_c_rdata, rdc);
        chk("d_rdata", o_d_rdata, rdd);
        chk("c_stall", o_c_stall, stall);
        chk("m_req", o_m_req, mreq);
        chk("m_wren", o_m_wren, mwren);
        chk("m_addr", o_m_addr, maddr);
        chk("m_wdata", o_m_wdata, mwdata);
        chk("m_bmask", o_m_bmask, mbm);

        s_req = o_m_req; s_wren = o_m_wren; s_addr = o_m_addr;
        s_wdata = o_m_wdata; s_bmask = o_m_bmask;

        if (rvc) held_c = rd_data;
        if (rvd) held_d = rd_data;
        if (mreq) begin
            last_was_dbg = e_gd;
            if (!mwren) begin
                resp_cyc   = cyc + LAT;
                rd_for_dbg = e_gd;
                rd_data    = mem[maddr[5:2]];
            end
        end
    endtask

    // Clock edge plus 1: advance cycle count and the bench SRAM.
    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = (s_req && !s_wren) ? mem[s_addr[5:2]] : $urandom();
        if (s_req && s_wren)
            for (int b = 0; b < 4; b++)
                if (s_bmask[b]) mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        i_m_rdata = pipe[LAT-1];
    endtask

    task automatic do_reset();
        i_reset = 1'b0; i_c_req = 1'b0; i_d_req = 1'b0;
        check_cycle();
        tick();
        i_reset = 1'b1;
    endtask

    task automatic rand_req(output logic wren, output logic [31:0] addr,
                            output logic [31:0] wdata, output logic [3:0] bm);
        wren  = 1'($urandom_range(0, 1));
        addr  = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
        wdata = $urandom();
        bm    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
        i_reset = 1'b0;
        i_c_req = 0; i_c_wren = 0; i_c_addr = 0; i_c_wdata = 0; i_c_bmask = 0;
        i_d_req = 0; i_d_wren = 0; i_d_addr = 0; i_d_wdata = 0; i_d_bmask = 0;
        i_m_rdata = 0;
        s_req = 0; s_wren = 0; s_addr = 0; s_wdata = 0; s_bmask = 0;
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
        for (int k = 0; k < 16; k++) mem[k] = $urandom();
        mem[4] = 32'hDEADBEEF;
        model_reset();

        // Reset state held for two cycles.
        check_cycle(); tick();
        check_cycle(); tick();
        i_reset = 1'b1;

        // Core read of 0x10, data back LAT cycles later.
        i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h10; i_c_wdata = 0; i_c_bmask = 4'hF;
        check_cycle(); chk("t1_c_gnt", o_c_gnt, 1'b1); tick();
        i_c_req = 0;
        for (int k = 1; k <= LAT; k++) begin
            check_cycle();
            chk("t1_c_rvalid", o_c_rvalid, 1'(k == LAT));
            if (k == LAT) chk("t1_c_rdata", o_c_rdata, 32'hDEADBEEF);
            tick();
        end
        check_cycle(); tick();

        // Two simultaneous writes after reset: core first, then debug.
        do_reset();
        i_c_req = 1; i_c_wren = 1; i_c_addr = 32'h20; i_c_wdata = 32'h11; i_c_bmask = 4'hF;
        i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h24; i_d_wdata = 32'h22; i_d_bmask = 4'hF;
        check_cycle(); chk("t2_c_gnt", o_c_gnt, 1'b1); chk("t2_addr0", o_m_addr, 32'h20); tick();
        i_c_req = 0;
        check_cycle(); chk("t2_d_gnt", o_d_gnt, 1'b1); chk("t2_addr1", o_m_addr, 32'h24); tick();
        i_d_req = 0;

        // Continuous writes from both: strict alternation starting with core.
        i_c_req = 1; i_d_req = 1;
        for (int k = 0; k < 6; k++) begin
            check_cycle();
            chk("t3_c_gnt", o_c_gnt, 1'(k % 2 == 0));
            chk("t3_m_req", o_m_req, 1'b1);
            tick();
        end
        i_c_req = 0; i_d_req = 0;
        check_cycle(); tick();

        // Debug read blocks a core write until the read returns.
        i_d_req = 1; i_d_wren = 0; i_d_addr = 32'h30;
        check_cycle(); chk("t4_d_gnt", o_d_gnt, 1'b1); tick();
        i_d_req = 0;
        i_c_req = 1; i_c_wren = 1; i_c_addr = 32'h34; i_c_wdata = 32'h55; i_c_bmask = 4'h3;
        for (int k = 1; k <= LAT; k++) begin
            check_cycle();
            chk("t4_c_stall", o_c_stall, 1'b1);
            chk("t4_c_gnt_held", o_c_gnt, 1'b0);
            chk("t4_d_rvalid", o_d_rvalid, 1'(k == LAT));
            tick();
        end
        check_cycle(); chk("t4_c_gnt_late", o_c_gnt, 1'b1); tick();
        i_c_req = 0;

        // Debug pulses a request during a core read wait: no access results.
        i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h08;
        check_cycle(); tick();
        i_c_req = 0;
        i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h3C; i_d_wdata = 32'h77; i_d_bmask = 4'hF;
        check_cycle(); chk("t6_d_gnt", o_d_gnt, 1'b0); chk("t6_m_req", o_m_req, 1'b0); tick();
        i_d_req = 0;
        for (int k = 0; k < LAT + 1; k++) begin
            check_cycle(); chk("t6_m_idle", o_m_req, 1'b0); tick();
        end

        // Reset during an outstanding core read discards it.
        i_c_req = 1; i_c_wren = 0; i_c_addr = 32'h10;
        check_cycle(); tick();
        i_c_req = 0;
        i_reset = 1'b0;
        check_cycle(); chk("t5_rst_stall", o_c_stall, 1'b0); chk("t5_rst_rdata", o_c_rdata, 32'h0); tick();
        check_cycle(); tick();
        i_reset = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            check_cycle(); chk("t5_no_rvalid", o_c_rvalid, 1'b0); tick();
        end
        i_c_req = 1; i_c_wren = 1; i_c_addr = 32'h00; i_c_wdata = 32'h1;
        i_d_req = 1; i_d_wren = 1; i_d_addr = 32'h04; i_d_wdata = 32'h2;
        check_cycle(); chk("t5_tie_core", o_c_gnt, 1'b1); tick();
        i_c_req = 0;
        check_cycle(); tick();
        i_d_req = 0;

        // Random traffic; requests hold until granted, may be withdrawn, and
        // no requester issues while its own read is outstanding.
        for (int n = 0; n < 600; n++) begin
            if (i_c_req && !e_gc) begin
                if ($urandom_range(0, 7) == 0) i_c_req = 0;
            end else if (cyc <= resp_cyc && !rd_for_dbg) begin
                i_c_req = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                i_c_req = 1;
                rand_req(i_c_wren, i_c_addr, i_c_wdata, i_c_bmask);
            end else begin
                i_c_req = 0;
            end
            if (i_d_req && !e_gd) begin
                if ($urandom_range(0, 7) == 0) i_d_req = 0;
            end else if (cyc <= resp_cyc && rd_for_dbg) begin
                i_d_req = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                i_d_req = 1;
                rand_req(i_d_wren, i_d_addr, i_d_wdata, i_d_bmask);
            end else begin
                i_d_req = 0;
            end
            check_cycle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
